// File: rtl/pit_8254_pkg.sv
// Shared constants for the 8254 PIT bus controller: port map, control-word
// field positions and read-back command bit positions.
package pit_8254_pkg;

  typedef enum logic [1:0] {
    PORT_CNT0 = 2'd0,
    PORT_CNT1 = 2'd1,
    PORT_CNT2 = 2'd2,
    PORT_CTRL = 2'd3
  } port_e;

  // Control word layout: SC[7:6] RW[5:4] MODE[3:1] BCD[0]
  localparam int SC_MSB   = 7;
  localparam int SC_LSB   = 6;
  localparam int RW_MSB   = 5;
  localparam int RW_LSB   = 4;
  localparam int MODE_MSB = 3;
  localparam int MODE_LSB = 1;
  localparam int BCD_BIT  = 0;

  localparam logic [1:0] SC_READBACK = 2'b11;
  localparam logic [1:0] RW_LATCH    = 2'b00;

  // Read-back command: both latch selects are active-low
  localparam int RB_NCOUNT_BIT  = 5;
  localparam int RB_NSTATUS_BIT = 4;
  localparam int RB_CNT0_BIT    = 1;

  localparam int NUM_COUNTERS = 3;

endpackage

// File: rtl/pit_clk_gen.sv
// Fractional-accumulator clock generator: derives a PIT_HZ square wave from
// CLK_HZ with at most one system-clock period of jitter per phase.
module pit_clk_gen #(
  parameter int CLK_HZ = 50_000_000,
  parameter int PIT_HZ = 1_193_182
) (
  input  logic clk,
  input  logic rst_n,
  output logic pit_clock
);

  localparam int ACC_W = $clog2(CLK_HZ + 2 * PIT_HZ);
  localparam logic [ACC_W-1:0] INC   = ACC_W'(2 * PIT_HZ);
  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ);

  if (2 * PIT_HZ >= CLK_HZ) begin : g_bad_ratio
    $error("pit_clk_gen: 2*PIT_HZ must be below CLK_HZ");
  end

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic             pit_q, pit_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    sum   = acc_q + INC;
    acc_d = sum;
    pit_d = pit_q;
    if (sum >= LIMIT) begin
      acc_d = sum - LIMIT;
      pit_d = ~pit_q;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      pit_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pit_q <= pit_d;
    end
  end

  assign pit_clock = pit_q;

endmodule

// File: rtl/pit_8254_ctrl.sv
// Bus front-end for three 8254 counters: strobe decode, registered read
// path, gate synchronisers, IRQ0 edge detect and the counter clock.
module pit_8254_ctrl
  import pit_8254_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int PIT_HZ = 1_193_182
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] io_address,
  input  logic       io_write,
  input  logic       io_read,
  input  logic [7:0] io_writedata,
  output logic [7:0] io_readdata,
  output logic       io_readdatavalid,
  output logic [7:0] cnt_data_in,
  output logic [2:0] cnt_set_control_mode,
  output logic [2:0] cnt_latch_count,
  output logic [2:0] cnt_latch_status,
  output logic [2:0] cnt_write,
  output logic [2:0] cnt_read,
  input  logic [7:0] cnt_data_out0,
  input  logic [7:0] cnt_data_out1,
  input  logic [7:0] cnt_data_out2,
  input  logic [2:0] cnt_out,
  input  logic [2:0] gate_in,
  output logic [2:0] cnt_gate,
  output logic       pit_clock,
  output logic       irq0
);

  logic [1:0] sc, rw;
  logic       rd_accept;
  logic [7:0] rd_mux;

  logic [7:0] readdata_q, readdata_d;
  logic       valid_q, valid_d;
  logic [2:0] gate_meta_q, gate_meta_d;
  logic [2:0] gate_sync_q, gate_sync_d;
  logic       out0_prev_q, out0_prev_d;
  logic       irq0_q, irq0_d;

  assign cnt_data_in = io_writedata;
  assign sc          = io_writedata[SC_MSB:SC_LSB];
  assign rw          = io_writedata[RW_MSB:RW_LSB];

  // Strobes follow the live bus cycle; a write always pre-empts a read.
  always_comb begin
    cnt_set_control_mode = '0;
    cnt_latch_count      = '0;
    cnt_latch_status     = '0;
    cnt_write            = '0;
    cnt_read             = '0;
    if (io_write) begin
      if (io_address == PORT_CTRL) begin
        if (sc == SC_READBACK) begin
          for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (io_writedata[RB_CNT0_BIT+i]) begin
              cnt_latch_count[i]  = ~io_writedata[RB_NCOUNT_BIT];
              cnt_latch_status[i] = ~io_writedata[RB_NSTATUS_BIT];
            end
          end
        end else if (rw == RW_LATCH) begin
          cnt_latch_count[sc] = 1'b1;
        end else begin
          cnt_set_control_mode[sc] = 1'b1;
        end
      end else begin
        cnt_write[io_address] = 1'b1;
      end
    end else if (io_read && io_address != PORT_CTRL) begin
      cnt_read[io_address] = 1'b1;
    end
  end

  always_comb begin
    unique case (io_address)
      PORT_CNT0: rd_mux = cnt_data_out0;
      PORT_CNT1: rd_mux = cnt_data_out1;
      PORT_CNT2: rd_mux = cnt_data_out2;
      default:   rd_mux = 8'hFF;
    endcase
    rd_accept   = io_read & ~io_write;
    readdata_d  = rd_accept ? rd_mux : readdata_q;
    valid_d     = rd_accept;
    gate_meta_d = gate_in;
    gate_sync_d = gate_meta_q;
    out0_prev_d = cnt_out[0];
    irq0_d      = cnt_out[0] & ~out0_prev_q;
  end

  // Sync and edge-detect flops reset high: gates open and no IRQ0 on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata_q  <= 8'h00;
      valid_q     <= 1'b0;
      gate_meta_q <= 3'b111;
      gate_sync_q <= 3'b111;
      out0_prev_q <= 1'b1;
      irq0_q      <= 1'b0;
    end else begin
      readdata_q  <= readdata_d;
      valid_q     <= valid_d;
      gate_meta_q <= gate_meta_d;
      gate_sync_q <= gate_sync_d;
      out0_prev_q <= out0_prev_d;
      irq0_q      <= irq0_d;
    end
  end

  assign io_readdata      = readdata_q;
  assign io_readdatavalid = valid_q;
  assign cnt_gate         = gate_sync_q;
  assign irq0             = irq0_q;

  pit_clk_gen #(
    .CLK_HZ(CLK_HZ),
    .PIT_HZ(PIT_HZ)
  ) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .pit_clock(pit_clock)
  );

endmodule

// File: tb/tb_pit_8254_ctrl.sv
// Scoreboard bench for pit_8254_ctrl: directed and random bus cycles against
// a behavioural model, plus gate, IRQ0 and counter-clock frequency checks.
module tb_pit_8254_ctrl;

  localparam int CLK_HZ  = 50_000_000;
  localparam int PIT_HZ  = 1_193_182;
  localparam int PIT_WIN = 40_000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] io_address;
  logic       io_write, io_read;
  logic [7:0] io_writedata, io_readdata;
  logic       io_readdatavalid;
  logic [7:0] cnt_data_in;
  logic [2:0] cnt_set_control_mode, cnt_latch_count, cnt_latch_status;
  logic [2:0] cnt_write, cnt_read;
  logic [7:0] cnt_data_out0, cnt_data_out1, cnt_data_out2;
  logic [2:0] cnt_out, gate_in, cnt_gate;
  logic       pit_clock, irq0;

  typedef struct packed {
    logic [2:0] scm;
    logic [2:0] lc;
    logic [2:0] ls;
    logic [2:0] wr;
    logic [2:0] rd;
  } strobes_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] last_rd = 8'h00;

  pit_8254_ctrl #(.CLK_HZ(CLK_HZ), .PIT_HZ(PIT_HZ)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .io_address          (io_address),
    .io_write            (io_write),
    .io_read             (io_read),
    .io_writedata        (io_writedata),
    .io_readdata         (io_readdata),
    .io_readdatavalid    (io_readdatavalid),
    .cnt_data_in         (cnt_data_in),
    .cnt_set_control_mode(cnt_set_control_mode),
    .cnt_latch_count     (cnt_latch_count),
    .cnt_latch_status    (cnt_latch_status),
    .cnt_write           (cnt_write),
    .cnt_read            (cnt_read),
    .cnt_data_out0       (cnt_data_out0),
    .cnt_data_out1       (cnt_data_out1),
    .cnt_data_out2       (cnt_data_out2),
    .cnt_out             (cnt_out),
    .gate_in             (gate_in),
    .cnt_gate            (cnt_gate),
    .pit_clock           (pit_clock),
    .irq0                (irq0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference decode written from the port map and control-word rules.
  function automatic strobes_t model_strobes(input bit w, input bit r, input int a, input int d);
    strobes_t s;
    int sc, rwf;
    s = '0;
    if (w) begin
      if (a < 3) begin
        s.wr[a] = 1'b1;
      end else begin
        sc  = (d >> 6) & 3;
        rwf = (d >> 4) & 3;
        if (sc == 3) begin
          for (int i = 0; i < 3; i++) begin
            if (((d >> (i + 1)) & 1) == 1) begin
              if (((d >> 5) & 1) == 0) s.lc[i] = 1'b1;
              if (((d >> 4) & 1) == 0) s.ls[i] = 1'b1;
            end
          end
        end else if (rwf == 0) begin
          s.lc[sc] = 1'b1;
        end else begin
          s.scm[sc] = 1'b1;
        end
      end
    end else if (r && a < 3) begin
      s.rd[a] = 1'b1;
    end
    return s;
  endfunction

  task automatic bus(input bit w, input bit r, input int a, input logic [7:0] d,
                     input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    strobes_t   s;
    logic [7:0] cdo [3];
    exp_t       e;
    @(negedge clk);
    io_write      = w;
    io_read       = r;
    io_address    = 2'(a);
    io_writedata  = d;
    cnt_data_out0 = c0;
    cnt_data_out1 = c1;
    cnt_data_out2 = c2;
    cdo[0] = c0;
    cdo[1] = c1;
    cdo[2] = c2;
    s = model_strobes(w, r, a, int'(d));
    if (r && !w) begin
      e.data = (a == 3) ? 8'hFF : cdo[a];
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    #1;
    check("set_control_mode", cnt_set_control_mode, s.scm);
    check("latch_count", cnt_latch_count, s.lc);
    check("latch_status", cnt_latch_status, s.ls);
    check("cnt_write", cnt_write, s.wr);
    check("cnt_read", cnt_read, s.rd);
    check("cnt_data_in", cnt_data_in, d);
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 0, 8'h00, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    sb.delete();
    last_rd = 8'h00;
    #1;
    check("rst_readdata", io_readdata, 8'h00);
    check("rst_valid", io_readdatavalid, 1'b0);
    check("rst_pit_clock", pit_clock, 1'b0);
    check("rst_gate", cnt_gate, 3'b111);
    check("rst_irq0", irq0, 1'b0);
    @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Read-data monitor: pops the scoreboard whenever the DUT qualifies data.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (io_readdatavalid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", io_readdatavalid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("rd_data", io_readdata, e.data);
          check("rd_latency", cyc, e.cyc);
          last_rd = e.data;
        end
      end else begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          check("rd_missing_valid", io_readdatavalid, 1'b1);
          void'(sb.pop_front());
        end
        check("rd_hold", io_readdata, last_rd);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op, a, rises, last_t, ph, min_ph, max_ph;
    bit w, r;
    logic prev;
    longint toggles;

    rst_n = 1'b0;
    io_address = '0; io_write = 1'b0; io_read = 1'b0; io_writedata = '0;
    cnt_data_out0 = '0; cnt_data_out1 = '0; cnt_data_out2 = '0;
    cnt_out = 3'b001;
    gate_in = 3'b111;
    do_reset();

    // cnt_out[0] high across reset release must not raise IRQ0
    repeat (3) begin
      @(negedge clk);
      check("irq0_after_release", irq0, 1'b0);
    end
    cnt_out[0] = 1'b0;
    @(negedge clk);
    check("irq0_low", irq0, 1'b0);
    cnt_out[0] = 1'b1;
    @(negedge clk);
    check("irq0_pulse", irq0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("irq0_held_level", irq0, 1'b0);
    end

    gate_in = 3'b010;
    @(negedge clk);
    check("gate_1cyc", cnt_gate, 3'b111);
    @(negedge clk);
    check("gate_2cyc", cnt_gate, 3'b010);
    gate_in = 3'b101;
    @(negedge clk);
    @(negedge clk);
    check("gate_2cyc_b", cnt_gate, 3'b101);

    // Directed bus cycles
    bus(1'b1, 1'b0, 3, 8'h36, 8'h00, 8'h00, 8'h00);
    bus(1'b1, 1'b0, 0, 8'h9C, 8'h00, 8'h00, 8'h00);
    bus(1'b1, 1'b0, 0, 8'h2E, 8'h00, 8'h00, 8'h00);
    bus(1'b1, 1'b0, 3, 8'hCA, 8'h00, 8'h00, 8'h00);
    bus(1'b1, 1'b0, 3, 8'hFE, 8'h00, 8'h00, 8'h00);
    bus(1'b1, 1'b0, 3, 8'h40, 8'h00, 8'h00, 8'h00);
    bus(1'b0, 1'b1, 1, 8'h00, 8'h11, 8'h5A, 8'h22);
    bus(1'b0, 1'b1, 3, 8'h00, 8'h11, 8'h5A, 8'h22);
    bus(1'b1, 1'b1, 2, 8'h77, 8'h11, 8'h5A, 8'h22);
    idle();
    idle();

    // Reset in the middle of a read: the valid strobe must never appear
    @(negedge clk);
    io_write = 1'b0; io_read = 1'b1; io_address = 2'd1; cnt_data_out1 = 8'hC3;
    #3 rst_n = 1'b0;
    sb.delete();
    last_rd = 8'h00;
    @(negedge clk);
    io_read = 1'b0;
    check("valid_in_reset", io_readdatavalid, 1'b0);
    check("readdata_in_reset", io_readdata, 8'h00);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("valid_after_reset", io_readdatavalid, 1'b0);

    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 7));
      w  = (op >= 2 && op <= 4) || op == 7;
      r  = (op == 5 || op == 6 || op == 7);
      a  = int'($urandom_range(0, 3));
      bus(w, r, a, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    idle();
    idle();
    idle();
    check("sb_drained", sb.size(), 0);

    // Counter clock: rising edges and phase lengths over a fixed window
    do_reset();
    prev = 1'b0; rises = 0; last_t = -1; min_ph = 1 << 30; max_ph = 0;
    for (int k = 1; k <= PIT_WIN; k++) begin
      @(negedge clk);
      if (pit_clock !== prev) begin
        if (last_t >= 0) begin
          ph = k - last_t;
          if (ph < min_ph) min_ph = ph;
          if (ph > max_ph) max_ph = ph;
        end
        last_t = k;
        if (pit_clock === 1'b1) rises++;
        prev = pit_clock;
      end
    end
    toggles = (longint'(PIT_WIN) * 2 * PIT_HZ) / CLK_HZ;
    check("pit_rising_edges", rises, 32'((toggles + 1) / 2));
    check("pit_min_phase", min_ph, CLK_HZ / (2 * PIT_HZ));
    check("pit_max_phase", max_ph, (CLK_HZ + 2 * PIT_HZ - 1) / (2 * PIT_HZ));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
